acc_stack: RTL and testbench
============================

ACC_STACK -- requirements
Module: acc_stack

Interface
REQ-001 Parameter WIDTH, default 8, data width; SHALL match the accumulator width.
REQ-002 Parameter DEPTH, default 8, number of stack entries; SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 push  input  1  save din onto the stack this cycle.
REQ-006 pop  input  1  restore the top entry this cycle.
REQ-007 din  input  WIDTH  value to save, driven from the accumulator output.
REQ-008 dout  output  WIDTH  restored value, registered, driven to the accumulator data input.
REQ-009 ld_en  output  1  one-cycle registered pulse, driven to the accumulator enable.
REQ-010 z_out  output  1  restored value is zero.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-014 err  output  1  sticky overflow/underflow flag; see Configuration.

Function
REQ-015 Storage SHALL be DEPTH x WIDTH entries; the top of the stack SHALL be entry count-1.
REQ-016 push only, not full: SHALL write din to entry count and increment count; dout and ld_en SHALL not change.
REQ-017 pop only, not empty: SHALL load dout with entry count-1, decrement count, and assert ld_en for exactly the next cycle.
REQ-018 Restore latency SHALL be one cycle: dout and ld_en SHALL be valid in the cycle after the pop edge.
REQ-019 push and pop together, not empty (including full): SHALL load dout with entry count-1, overwrite that entry with din, keep count unchanged, and pulse ld_en.
REQ-020 push and pop together, empty: SHALL act as push only; the pop SHALL be flagged as underflow.
REQ-021 push only while full SHALL be ignored: storage and count SHALL be unchanged; the push SHALL be flagged as overflow.
REQ-022 pop only while empty SHALL be ignored: dout unchanged, ld_en 0; the pop SHALL be flagged as underflow.
REQ-023 ld_en SHALL be 0 in every cycle not immediately following an accepted pop; back-to-back pops SHALL give consecutive ld_en pulses with successive entries.
REQ-024 dout SHALL hold the last restored value until the next accepted pop.
REQ-025 z_out SHALL equal ld_en AND (dout == 0), decoded combinationally from registers.
REQ-026 full, empty and count SHALL be derived from the registered count with no added latency.

Reset
REQ-027 When rst is 1 at a clock edge: count SHALL become 0, dout 0, ld_en 0, and err 0; empty SHALL be 1, full 0, z_out 0.
REQ-028 push and pop SHALL be ignored in any cycle where rst is 1; reset SHALL take priority over all operations.
REQ-029 Storage contents SHALL NOT be reset; reading them is only reachable through an accepted pop after a push.

Configuration
REQ-030 Macro ACC_STACK_ERR_EN: when defined, err SHALL be set by any overflow or underflow event and SHALL stay set until rst.
REQ-031 Without ACC_STACK_ERR_EN: err SHALL be tied to 0 and no error register SHALL exist. The ignore behaviour of REQ-021 and REQ-022 SHALL be identical in both builds.

Verification
REQ-032 The bench SHALL cover the following scenarios:
- rst, then push 0x11, 0x22, 0x33, then 3 pops: dout = 0x33, 0x22, 0x11 on successive cycles; ld_en high for 3 cycles; empty = 1.
- Push 0x00, then pop: one cycle later dout = 0x00, ld_en = 1, z_out = 1; the following cycle z_out = 0.
- Fill to DEPTH with 0x01..0x08, then push 0xFF: count stays 8 and full = 1; popping all entries returns 0x08..0x01; err = 1 only if ACC_STACK_ERR_EN is defined.
- Pop while empty: ld_en = 0, dout unchanged, count = 0; err per macro.
- With count = 2 (top 0x22), push and pop together with din = 0x55: dout = 0x22, ld_en = 1, count = 2; the next pop returns 0x55.
- rst asserted together with push after 3 entries: count = 0, err = 0, and that push is not stored.

Source files
------------

// File: rtl/acc_stack_if.sv
// Bus between the accumulator datapath and its save/restore stack.
// The master drives push/pop/din; the slave returns the restored value and status.
interface acc_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             ld_en;
    logic             z_out;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             err;

    modport master (
        output push, pop, din,
        input  dout, ld_en, z_out, full, empty, count, err
    );

    modport slave (
        input  push, pop, din,
        output dout, ld_en, z_out, full, empty, count, err
    );
endinterface

// File: rtl/acc_stack.sv
// LIFO save/restore stack for an accumulator; a pop reloads the accumulator one cycle later.
// Optional sticky overflow/underflow flag enabled by defining ACC_STACK_ERR_EN.
module acc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    acc_stack_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] dout_reg;
    logic             ld_en_reg;

    logic             full_w;
    logic             empty_w;
    logic             accept_pop;
    logic             accept_push;
    logic             overflow;
    logic             underflow;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;

    assign full_w  = (count_reg == CW'(DEPTH));
    assign empty_w = (count_reg == '0);

    always_comb begin
        accept_pop  = 1'b0;
        accept_push = 1'b0;
        overflow    = 1'b0;
        underflow   = 1'b0;
        count_next  = count_reg;
        top_idx     = AW'(count_reg - CW'(1));
        wr_idx      = AW'(count_reg);

        accept_pop  = bus.pop & ~empty_w;
        // A simultaneous pop frees the top slot, so push+pop is accepted even when full.
        accept_push = bus.push & (~full_w | accept_pop);
        overflow    = bus.push & ~bus.pop & full_w;
        underflow   = bus.pop & empty_w;

        if (accept_pop) begin
            wr_idx = top_idx;
        end

        if (accept_push && !accept_pop) begin
            count_next = count_reg + CW'(1);
        end else if (accept_pop && !accept_push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            dout_reg  <= '0;
            ld_en_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            ld_en_reg <= accept_pop;
            if (accept_pop) begin
                dout_reg <= mem[top_idx];
            end
        end
    end

    // Storage is never cleared; read-before-write gives the old top on push+pop.
    always_ff @(posedge clk) begin
        if (!rst && accept_push) begin
            mem[wr_idx] <= bus.din;
        end
    end

`ifdef ACC_STACK_ERR_EN
    logic err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (overflow || underflow) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err = err_reg;
`else
    logic unused_flags;
    assign unused_flags = overflow | underflow;
    assign bus.err      = 1'b0;
`endif

    assign bus.dout  = dout_reg;
    assign bus.ld_en = ld_en_reg;
    assign bus.z_out = ld_en_reg & (dout_reg == '0);
    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.count = count_reg;
endmodule

// File: tb/tb_acc_stack.sv
// Randomized and directed check of acc_stack against a queue-based LIFO model.
// Error-flag expectations follow ACC_STACK_ERR_EN.
module tb_acc_stack;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef ACC_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    acc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    acc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total = 0;
    int checks_failed = 0;

    // Reference model: the stack as a queue, bottom at index 0.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] dout_m;
    bit               ld_m;
    bit               err_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            checks_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit p, input bit q, input logic [WIDTH-1:0] d);
        if (r) begin
            model_q.delete();
            dout_m = '0;
            ld_m   = 1'b0;
            err_m  = 1'b0;
        end else begin
            ld_m = 1'b0;
            if (q && model_q.size() > 0) begin
                dout_m = model_q[model_q.size() - 1];
                ld_m   = 1'b1;
                void'(model_q.pop_back());
                if (p) model_q.push_back(d);
            end else begin
                if (q && ERR_EN) err_m = 1'b1;
                if (p) begin
                    if (model_q.size() < DEPTH) model_q.push_back(d);
                    else if (ERR_EN) err_m = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("count", 32'(bus.count), 32'(model_q.size()));
        check("dout",  32'(bus.dout),  32'(dout_m));
        check("ld_en", 32'(bus.ld_en), 32'(ld_m));
        check("z_out", 32'(bus.z_out), 32'(ld_m && dout_m == '0));
        check("full",  32'(bus.full),  32'(model_q.size() == DEPTH));
        check("empty", 32'(bus.empty), 32'(model_q.size() == 0));
        check("err",   32'(bus.err),   32'(err_m));
    endtask

    // One clock: drive, advance, update the model, sample #1 after the edge.
    task automatic cycle(input bit r, input bit p, input bit q, input logic [WIDTH-1:0] d);
        rst      = r;
        bus.push = p;
        bus.pop  = q;
        bus.din  = d;
        @(posedge clk);
        model_step(r, p, q, d);
        #1;
        compare_all();
        $display("txn rst=%0b push=%0b pop=%0b din=%02h -> dout=%02h ld_en=%0b z=%0b count=%0d err=%0b",
                 r, p, q, d, bus.dout, bus.ld_en, bus.z_out, bus.count, bus.err);
    endtask

    initial begin
        rst      = 1'b1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.din  = '0;
        model_q.delete();
        dout_m = '0;
        ld_m   = 1'b0;
        err_m  = 1'b0;
        #2;

        // Reset state.
        cycle(1, 1, 1, 8'hAA);
        cycle(1, 0, 0, 8'h00);
        check("rst_empty", 32'(bus.empty), 32'd1);

        // Push three, pop three in order.
        cycle(0, 1, 0, 8'h11);
        cycle(0, 1, 0, 8'h22);
        cycle(0, 1, 0, 8'h33);
        cycle(0, 0, 1, 8'h00);
        check("pop1_dout", 32'(bus.dout), 32'h33);
        cycle(0, 0, 1, 8'h00);
        check("pop2_dout", 32'(bus.dout), 32'h22);
        cycle(0, 0, 1, 8'h00);
        check("pop3_dout", 32'(bus.dout), 32'h11);
        check("pop3_ld",   32'(bus.ld_en), 32'd1);
        cycle(0, 0, 0, 8'h00);
        check("drained_empty", 32'(bus.empty), 32'd1);
        check("ld_after", 32'(bus.ld_en), 32'd0);

        // Zero restore flags z_out for one cycle only.
        cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 1, 8'h00);
        check("zero_z", 32'(bus.z_out), 32'd1);
        cycle(0, 0, 0, 8'h00);
        check("zero_z_drop", 32'(bus.z_out), 32'd0);

        // Fill, overflow push, drain.
        for (int i = 1; i <= DEPTH; i++) cycle(0, 1, 0, 8'(i));
        cycle(0, 1, 0, 8'hFF);
        check("ovf_count", 32'(bus.count), 32'(DEPTH));
        check("ovf_full",  32'(bus.full),  32'd1);
        check("ovf_err",   32'(bus.err),   32'(ERR_EN));
        for (int i = DEPTH; i >= 1; i--) begin
            cycle(0, 0, 1, 8'h00);
            check("drain", 32'(bus.dout), 32'(i));
        end

        // Underflow pop holds dout.
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 0, 8'h7E);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 1, 8'h00);
        check("unf_dout", 32'(bus.dout), 32'h7E);
        check("unf_ld",   32'(bus.ld_en), 32'd0);
        check("unf_err",  32'(bus.err), 32'(ERR_EN));

        // Push+pop swap at count 2; push+pop on empty acts as push.
        cycle(0, 1, 1, 8'h5A);
        check("pp_empty_count", 32'(bus.count), 32'd1);
        cycle(1, 0, 0, 8'h00);
        cycle(0, 1, 0, 8'h11);
        cycle(0, 1, 0, 8'h22);
        cycle(0, 1, 1, 8'h55);
        check("swap_dout",  32'(bus.dout), 32'h22);
        check("swap_count", 32'(bus.count), 32'd2);
        cycle(0, 0, 1, 8'h00);
        check("swap_next", 32'(bus.dout), 32'h55);

        // Reset with push after three entries: push is dropped.
        cycle(0, 1, 0, 8'hA1);
        cycle(0, 1, 0, 8'hA2);
        cycle(1, 1, 0, 8'hC3);
        check("rstpush_count", 32'(bus.count), 32'd0);
        check("rstpush_err",   32'(bus.err), 32'd0);
        cycle(0, 0, 1, 8'h00);
        check("rstpush_ld", 32'(bus.ld_en), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            logic [WIDTH-1:0] d;
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_total, checks_failed);
        $finish;
    end
endmodule
